dram_bank_ctrl: RTL and testbench

Single-bank DRAM controller and storage model that sits directly below the PIM units. It accepts row-granular read, write and close requests and enforces the precharge, discharge and activation delays from the `types` package. Each 512-bit row is moved as 64-bit beats in bursts of `BURST_LEN`. An open-row policy lets back-to-back accesses to the same row skip bank timing.

---
 rtl/dram_bank_ctrl.sv | 160 ++++++++++++++++
 tb/tb_dram_bank_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dram_bank_ctrl.sv
// dram_bank_ctrl: single-bank DRAM controller with row-buffer storage model and open-row policy
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_op, req_addr              00 read, 01 write, 1x close; row index
//   wdata/wdata_valid/wdata_ready write beat stream into the row buffer
//   rdata/rdata_valid             read beat stream from the row buffer (no backpressure)
//   done                          one-cycle completion pulse
//   row_open, open_row            row buffer status
module dram_bank_ctrl #(
  parameter int ROW_WIDTH = 512,
  parameter int BURST_ACCESS_WIDTH = 64,
  parameter int BURST_LEN = 4,
  parameter int NUM_ROWS = 1024,
  parameter int ADDRESS_LEN = 10,
  parameter int PRECHARGE_CYCLES = 10,
  parameter int DISCHARGE_CYCLES = 10,
  parameter int BANK_ACTIVATION_CYCLES = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [ADDRESS_LEN-1:0]        req_addr,
  input  logic [BURST_ACCESS_WIDTH-1:0] wdata,
  input  logic                          wdata_valid,
  output logic                          wdata_ready,
  output logic [BURST_ACCESS_WIDTH-1:0] rdata,
  output logic                          rdata_valid,
  output logic                          done,
  output logic                          row_open,
  output logic [$clog2(NUM_ROWS)-1:0]   open_row
);
  localparam int BEATS = ROW_WIDTH / BURST_ACCESS_WIDTH;
  localparam int RW = $clog2(NUM_ROWS);
  localparam int BW = $clog2(BEATS);
  localparam logic [15:0] PRE_END = 16'(PRECHARGE_CYCLES - 1);
  localparam logic [15:0] DIS_END = 16'(DISCHARGE_CYCLES - 1);
  localparam logic [15:0] ACT_END = 16'(BANK_ACTIVATION_CYCLES - 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  // Bursts are streamed back-to-back, so burst length only constrains the row geometry.
  if (BEATS % BURST_LEN != 0) begin : g_chk
    $error("row must hold a whole number of bursts");
  end
  typedef enum logic [2:0] {IDLE, PRE, DIS, ACT, XFER_RD, XFER_WR, FIN} state_t;
  state_t state;
  logic [15:0] cnt;
  logic [BW-1:0] beat;
  logic [BW-1:0] nxt_beat;
  logic op_rd;
  logic op_cl;
  logic [RW-1:0] row;
  logic [RW-1:0] addr_row;
  logic [ROW_WIDTH-1:0] mem [NUM_ROWS];
  logic [ROW_WIDTH-1:0] row_buf;
  logic [ROW_WIDTH-1:0] act_row;
  logic pre_end;
  logic act_end;
  logic wr_take;
  assign addr_row = req_addr[RW-1:0];
  assign nxt_beat = beat + BW'(1);
  assign act_row = mem[row];
  assign pre_end = state == PRE && cnt == PRE_END;
  assign act_end = state == ACT && cnt == ACT_END;
  assign wr_take = state == XFER_WR && wdata_valid && wdata_ready;
  // Storage is never reset; the array only changes on write-back at the end of precharge.
  always_ff @(posedge clk) begin
    if (pre_end) mem[open_row] <= row_buf;
    if (act_end) row_buf <= act_row;
    else if (wr_take) row_buf[beat*BURST_ACCESS_WIDTH +: BURST_ACCESS_WIDTH] <= wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      beat <= '0;
      op_rd <= 1'b0;
      op_cl <= 1'b0;
      row <= '0;
      req_ready <= 1'b1;
      rdata <= '0;
      rdata_valid <= 1'b0;
      wdata_ready <= 1'b0;
      done <= 1'b0;
      row_open <= 1'b0;
      open_row <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          op_rd <= req_op == 2'b00;
          op_cl <= req_op[1];
          row <= addr_row;
          cnt <= '0;
          beat <= '0;
          if (req_op[1]) begin
            state <= row_open ? PRE : FIN;
            done <= !row_open;
          end else if (row_open && open_row == addr_row) begin
            state <= req_op[0] ? XFER_WR : XFER_RD;
            rdata_valid <= !req_op[0];
            wdata_ready <= req_op[0];
            if (!req_op[0]) rdata <= row_buf[0 +: BURST_ACCESS_WIDTH];
          end else begin
            state <= row_open ? PRE : ACT;
          end
        end
        PRE: if (cnt == PRE_END) begin
          state <= DIS;
          cnt <= '0;
          row_open <= 1'b0;
        end else begin
          cnt <= cnt + 16'd1;
        end
        DIS: if (cnt == DIS_END) begin
          state <= op_cl ? FIN : ACT;
          cnt <= '0;
          done <= op_cl;
        end else begin
          cnt <= cnt + 16'd1;
        end
        // The first read beat comes straight from the array so it lines up with the row load.
        ACT: if (cnt == ACT_END) begin
          state <= op_rd ? XFER_RD : XFER_WR;
          row_open <= 1'b1;
          open_row <= row;
          rdata_valid <= op_rd;
          wdata_ready <= !op_rd;
          if (op_rd) rdata <= act_row[0 +: BURST_ACCESS_WIDTH];
        end else begin
          cnt <= cnt + 16'd1;
        end
        XFER_RD: if (beat == LAST) begin
          state <= FIN;
          rdata_valid <= 1'b0;
          done <= 1'b1;
        end else begin
          beat <= nxt_beat;
          rdata <= row_buf[nxt_beat*BURST_ACCESS_WIDTH +: BURST_ACCESS_WIDTH];
        end
        XFER_WR: if (wdata_valid) begin
          if (beat == LAST) begin
            state <= FIN;
            wdata_ready <= 1'b0;
            done <= 1'b1;
          end else begin
            beat <= nxt_beat;
          end
        end
        FIN: begin
          state <= IDLE;
          done <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dram_bank_ctrl.sv
// tb_dram_bank_ctrl: randomized and directed checks of dram_bank_ctrl against a row-level model
module tb_dram_bank_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0;
  logic req_ready;
  logic [1:0] req_op = 0;
  logic [9:0] req_addr = 0;
  logic [63:0] wdata = 0;
  logic wdata_valid = 0;
  logic wdata_ready;
  logic [63:0] rdata;
  logic rdata_valid;
  logic done;
  logic row_open;
  logic [9:0] open_row;
  int n_tests = 0;
  int n_fail = 0;
  logic [511:0] mem_m [int];
  logic [511:0] buf_m;
  bit buf_known = 0;
  bit open_m = 0;
  int orow_m = 0;
  logic [63:0] d [8];
  always #5 clk = ~clk;
  dram_bank_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .row_open(row_open), .open_row(open_row)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_rdata_valid"}, rdata_valid, 0);
    chk({tag, "_wdata_ready"}, wdata_ready, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_row_open"}, row_open, 0);
    chk({tag, "_open_row"}, open_row, 0);
  endtask
  // One request from accept to return to IDLE; latency and data come from the row-level model.
  task automatic run_req(input int op, input int addr, input int stall_at, input int stall_len);
    int lat, nb, sc, first, exp_done;
    bit is_cl, is_wr, seen_done;
    is_cl = op >= 2;
    is_wr = op == 1;
    if (is_cl) lat = open_m ? 20 : 0;
    else lat = !open_m ? 20 : (orow_m == addr ? 0 : 40);
    exp_done = is_cl ? lat + 1 : lat + 9 + ((is_wr && stall_at >= 0 && stall_at < 8) ? stall_len : 0);
    if (is_cl || !(open_m && orow_m == addr)) begin
      if (open_m && buf_known) mem_m[orow_m] = buf_m;
      open_m = 0;
      if (!is_cl) begin
        buf_known = mem_m.exists(addr);
        buf_m = buf_known ? mem_m[addr] : '0;
        open_m = 1;
        orow_m = addr;
      end
    end
    @(negedge clk);
    chk("ready_accept", req_ready, 1);
    req_valid = 1;
    req_op = op[1:0];
    req_addr = addr[9:0];
    nb = 0;
    sc = 0;
    first = -1;
    seen_done = 0;
    for (int c = 1; c <= 200 && !seen_done; c++) begin
      @(negedge clk);
      req_valid = 0;
      wdata_valid = 0;
      if (c == 1) chk("ready_busy", req_ready, 0);
      if (rdata_valid) begin
        if (first < 0) first = c;
        if (buf_known && nb < 8) chk("rdata", rdata, buf_m[nb*64 +: 64]);
        nb++;
      end
      if (wdata_ready) begin
        if (first < 0) first = c;
        if (nb == stall_at && sc < stall_len) sc++;
        else if (nb < 8) begin
          wdata_valid = 1;
          wdata = d[nb];
          nb++;
        end
      end
      if (done) begin
        seen_done = 1;
        chk("done_cycle", c, exp_done);
      end
    end
    chk("done_seen", seen_done, 1);
    if (!is_cl) begin
      chk("first_beat_cycle", first, lat + 1);
      chk("beat_count", nb, 8);
    end
    if (is_wr) begin
      for (int k = 0; k < 8; k++) buf_m[k*64 +: 64] = d[k];
      buf_known = 1;
    end
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    chk("row_open", row_open, open_m);
    if (open_m) chk("open_row", open_row, orow_m);
  endtask
  initial begin
    int op, addr, sa, sl;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    for (int k = 0; k < 8; k++) d[k] = 64'h3000 + k;
    run_req(1, 3, -1, 0);
    run_req(0, 3, -1, 0);
    run_req(0, 7, -1, 0);
    run_req(0, 3, -1, 0);
    for (int k = 0; k < 8; k++) d[k] = 64'h3100 + k;
    run_req(1, 3, 4, 3);
    run_req(0, 3, -1, 0);
    run_req(2, 0, -1, 0);
    run_req(2, 0, -1, 0);
    @(negedge clk);
    req_valid = 1;
    req_op = 2'b00;
    req_addr = 10'd3;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      req_valid = 0;
    end
    rst = 1;
    #1;
    chk_reset_outputs("midact");
    @(negedge clk);
    rst = 0;
    open_m = 0;
    buf_known = 0;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_row_open", row_open, 0);
    run_req(0, 3, -1, 0);
    for (int k = 0; k < 8; k++) d[k] = 64'hFFFF_0000 + k;
    run_req(1, 1023, -1, 0);
    run_req(2, 0, -1, 0);
    run_req(0, 1023, -1, 0);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0: addr = 3;
        1: addr = 7;
        2: addr = 1023;
        default: addr = $urandom_range(0, 1023);
      endcase
      for (int k = 0; k < 8; k++) d[k] = {$urandom, $urandom};
      sa = op == 1 ? $urandom_range(0, 9) : -1;
      sl = $urandom_range(0, 4);
      run_req(op, addr, sa, sl);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
